ex_sorter_sorter_valrdy: RTL and testbench
==========================================

Name: ex_sorter_sorter_valrdy

Overview:
Four-element, N-bit sorting unit with a full val/rdy stream interface and backpressure. Each transaction carries its own mode: ascending or descending order, and signed or unsigned comparison. Three-stage pipeline with one compare-and-swap per element pair on the critical path of each stage: pairs (0,1)(2,3), then (0,2)(1,3), then (1,2). Sits between a val/rdy producer and consumer in the sorter example subsystem; it is a drop-in for stall-capable datapaths.

Parameters:
p_nbits, 8, element width in bits; must be >= 2.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
in_val  in  1  input transaction valid.
in_rdy  out  1  unit can accept an input this cycle.
in_desc  in  1  1 = descending order, 0 = ascending.
in_sgn  in  1  1 = two's-complement comparison, 0 = unsigned.
in0..in3  in  p_nbits each  elements to sort.
out_val  out  1  sorted result valid.
out_rdy  in  1  consumer accepts the result this cycle.
out0..out3  out  p_nbits each  sorted elements; out0 is first in the requested order.

Behaviour:
- Transfer occurs on a side when val && rdy are both high at posedge clk.
- Pipeline registers S1, S2, S3 each hold val, desc, sgn and elm0..3.
- Stage S1 sorts (0,1) and (2,3). Stage S2 sorts (0,2) and (1,3). Stage S3 sorts (1,2); elm0 and elm3 pass through. Outputs are taken combinationally from S3 logic.
- Compare-and-swap(a, b):
  - swap when the order is violated: a > b if ascending, a < b if descending.
  - comparison is signed iff sgn, else unsigned.
  - equal values are never swapped.
  - if the comparison evaluates to X, both outputs are X.
- Stall control, evaluated per stage from output to input:
  - go_S3 = out_rdy || !val_S3.
  - go_S2 = go_S3 || !val_S2.
  - go_S1 = go_S2 || !val_S1.
  - in_rdy = go_S1 && !reset.
  - a stage register loads only when its go is high; otherwise it holds.
  - a stage whose successor loads but which itself receives no new valid data clears val.
  - no bubble-squashing beyond these rules.
- out_val = val_S3.
- Latency: 3 cycles from input transfer to out_val with no stall. Throughput: 1 transaction per cycle while out_rdy is held high.
- Capacity: 3 transactions. With out_rdy low and the pipeline full, in_rdy is 0.
- The ready path from out_rdy to in_rdy is combinational. No combinational path from in_val to out_val.
- Order preservation: results leave in acceptance order; no drop, no duplication under any stall pattern.
- Mode bits travel with their data, so back-to-back transactions may use different modes.
- Reset:
  - val_S1/S2/S3 <= 0; out_val = 0 in the cycle after reset is sampled high and until new data arrives.
  - in_rdy = 0 while reset is high.
  - data and mode registers are not reset; out0..3 are don't-care while out_val = 0.
  - reset mid-operation discards all in-flight transactions; a transaction presented during reset is not accepted.
- When out_val = 1 and out_rdy = 0, out0..3 and out_val hold stable until transfer.
- Assertions (non-synthesis): in_val, in_rdy, out_val, out_rdy and val_S1..S3 are not X when not in reset.
- Line trace: in, S1, S2, S3, out fields, each showing val/rdy state.

Decomposition:
- Package ex_sorter_pkg: mode bit constants ORDER_ASC = 0, ORDER_DESC = 1, CMP_UNSIGNED = 0, CMP_SIGNED = 1.
- One sub-module, ex_sorter_cmp_swap, parametrised on p_nbits.
  - inputs: a, b, desc, sgn.
  - outputs: lo_first, hi_first, i.e. the pair in requested order.
  - purely combinational; instantiated 5 times.
- Pipeline registers and stall control stay in the top module.

Test Plan:
1. p_nbits=8, asc, unsigned: in {03,01,04,02} with out_rdy=1 -> out {01,02,03,04}, out_val=1 exactly 3 cycles after the input transfer.
2. Descending, same data {03,01,04,02} -> {04,03,02,01}. Then ties {05,05,05,05} -> {05,05,05,05} and {02,07,02,07} asc -> {02,02,07,07}.
3. Signed vs unsigned, back-to-back:
   - {80,01,FF,00} sgn=1 asc -> {80,FF,00,01}.
   - next cycle same data sgn=0 asc -> {00,01,80,FF}.
   - results arrive on consecutive cycles.
4. Backpressure: stream 6 distinct transactions with in_val=1 and out_rdy=0 for cycles 2-8.
   - in_rdy falls once 3 are held.
   - out0..3 stay stable while stalled.
   - after release, all 6 results appear in order with no loss or duplication.
   - repeat with random out_rdy over 200 transactions against a software reference model.
5. Reset mid-operation: accept 2 transactions, assert reset for 1 cycle.
   - out_val=0 and in_rdy=0 during reset.
   - neither transaction emerges afterwards.
   - a new transaction {09,08,07,06} asc yields {06,07,08,09} after 3 cycles.
6. Width sweep p_nbits=2, 16, 32: random 500 transactions with random modes vs reference model; extremes 0, max, min-signed included.

Source files
------------

// File: rtl/ex_sorter_pkg.sv
// Shared mode-bit encodings for the four-element val/rdy sorter.
package ex_sorter_pkg;
   localparam logic ORDER_ASC    = 1'b0;
   localparam logic ORDER_DESC   = 1'b1;
   localparam logic CMP_UNSIGNED = 1'b0;
   localparam logic CMP_SIGNED   = 1'b1;
endpackage

// File: rtl/ex_sorter_cmp_swap.sv
// Compare-and-swap cell: emits the pair (a, b) in the requested order.
module ex_sorter_cmp_swap
   import ex_sorter_pkg::*;
#(
   parameter int p_nbits = 8
) (
   input  logic [p_nbits-1:0] a,
   input  logic [p_nbits-1:0] b,
   input  logic               desc,
   input  logic               sgn,
   output logic [p_nbits-1:0] lo_first,
   output logic [p_nbits-1:0] hi_first
);
   logic               w_gt;
   logic               w_lt;
   logic               w_swap;
   logic [p_nbits-1:0] w_xpoison;

   assign w_gt   = (sgn == CMP_SIGNED) ? ($signed(a) > $signed(b)) : (a > b);
   assign w_lt   = (sgn == CMP_SIGNED) ? ($signed(a) < $signed(b)) : (a < b);
   assign w_swap = (desc == ORDER_DESC) ? w_lt : w_gt;

   // An unknown compare result poisons both outputs in simulation; it folds to zero in hardware.
   assign w_xpoison = {p_nbits{w_swap ^ w_swap}};

   assign lo_first = (w_swap ? b : a) ^ w_xpoison;
   assign hi_first = (w_swap ? a : b) ^ w_xpoison;
endmodule

// File: rtl/ex_sorter_sorter_valrdy.sv
// Three-stage pipelined 4-element sorter with val/rdy handshakes and per-transaction mode.
module ex_sorter_sorter_valrdy
   import ex_sorter_pkg::*;
#(
   parameter int p_nbits = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_val,
   output logic               in_rdy,
   input  logic               in_desc,
   input  logic               in_sgn,
   input  logic [p_nbits-1:0] in0,
   input  logic [p_nbits-1:0] in1,
   input  logic [p_nbits-1:0] in2,
   input  logic [p_nbits-1:0] in3,
   output logic               out_val,
   input  logic               out_rdy,
   output logic [p_nbits-1:0] out0,
   output logic [p_nbits-1:0] out1,
   output logic [p_nbits-1:0] out2,
   output logic [p_nbits-1:0] out3
);
   typedef struct packed {
      logic                    desc;
      logic                    sgn;
      logic [3:0][p_nbits-1:0] elm;
   } stage_t;

   logic [3:1]              r_vld;
   stage_t                  r_s1, r_s2, r_s3;
   stage_t                  w_n2, w_n3;
   logic [3:0][p_nbits-1:0] w_c1, w_c2;
   logic [p_nbits-1:0]      w_c3_lo, w_c3_hi;
   logic                    w_go1, w_go2, w_go3;

   // Ready ripples back from the consumer; an empty stage can always accept.
   assign w_go3  = out_rdy || !r_vld[3];
   assign w_go2  = w_go3 || !r_vld[2];
   assign w_go1  = w_go2 || !r_vld[1];
   assign in_rdy = w_go1 && !reset;

   for (genvar i = 0; i < 2; i++) begin : g_s1
      ex_sorter_cmp_swap #(.p_nbits(p_nbits)) u_cas (
         .a(r_s1.elm[2*i]), .b(r_s1.elm[2*i+1]), .desc(r_s1.desc), .sgn(r_s1.sgn),
         .lo_first(w_c1[2*i]), .hi_first(w_c1[2*i+1])
      );
   end

   for (genvar i = 0; i < 2; i++) begin : g_s2
      ex_sorter_cmp_swap #(.p_nbits(p_nbits)) u_cas (
         .a(r_s2.elm[i]), .b(r_s2.elm[i+2]), .desc(r_s2.desc), .sgn(r_s2.sgn),
         .lo_first(w_c2[i]), .hi_first(w_c2[i+2])
      );
   end

   ex_sorter_cmp_swap #(.p_nbits(p_nbits)) u_cas_s3 (
      .a(r_s3.elm[1]), .b(r_s3.elm[2]), .desc(r_s3.desc), .sgn(r_s3.sgn),
      .lo_first(w_c3_lo), .hi_first(w_c3_hi)
   );

   assign w_n2 = '{desc: r_s1.desc, sgn: r_s1.sgn, elm: w_c1};
   assign w_n3 = '{desc: r_s2.desc, sgn: r_s2.sgn, elm: w_c2};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld <= '0;
      end else begin
         if (w_go1) r_vld[1] <= in_val;
         if (w_go2) r_vld[2] <= r_vld[1];
         if (w_go3) r_vld[3] <= r_vld[2];
      end
   end

   // Payload registers are don't-care while their valid is low, so they carry no reset.
   always_ff @(posedge clk) begin
      if (w_go1) begin
         r_s1.desc <= in_desc;
         r_s1.sgn  <= in_sgn;
         r_s1.elm  <= {in3, in2, in1, in0};
      end
      if (w_go2) r_s2 <= w_n2;
      if (w_go3) r_s3 <= w_n3;
   end

   assign out_val = r_vld[3];
   assign out0    = r_s3.elm[0];
   assign out1    = w_c3_lo;
   assign out2    = w_c3_hi;
   assign out3    = r_s3.elm[3];

   a_ctl_known: assert property (@(posedge clk) disable iff (reset)
      !$isunknown({in_val, in_rdy, out_val, out_rdy, r_vld}));
endmodule

// File: tb/tb_ex_sorter_sorter_valrdy.sv
// Directed and reference-model checks for the val/rdy sorter at widths 8, 2, 16 and 32.
module tb_ex_sorter_sorter_valrdy;
   import ex_sorter_pkg::*;

   logic       clk;
   logic       reset, sw_reset;
   logic       in_val, in_rdy, in_desc, in_sgn, out_val, out_rdy;
   logic [7:0] in0, in1, in2, in3, out0, out1, out2, out3;

   int          n_chk = 0;
   int          n_err = 0;
   int          n_out = 0;
   bit          acc;
   logic [31:0] nxt_exp;
   logic [31:0] exp_q[$];

   ex_sorter_sorter_valrdy #(.p_nbits(8)) dut (
      .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy),
      .in_desc(in_desc), .in_sgn(in_sgn),
      .in0(in0), .in1(in1), .in2(in2), .in3(in3),
      .out_val(out_val), .out_rdy(out_rdy),
      .out0(out0), .out1(out1), .out2(out2), .out3(out3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   // Plain selection sort on width-corrected keys.
   function automatic logic [127:0] ref_sort(input int w, input bit d, input bit s,
                                             input logic [31:0] x0, x1, x2, x3);
      logic [31:0] v[4];
      longint      k[4];
      logic [31:0] tv;
      longint      tk;
      v[0] = x0; v[1] = x1; v[2] = x2; v[3] = x3;
      for (int i = 0; i < 4; i++)
         k[i] = (s && v[i][w-1]) ? longint'(v[i]) - (longint'(1) << w) : longint'(v[i]);
      for (int i = 0; i < 3; i++)
         for (int j = i + 1; j < 4; j++)
            if (d ? (k[j] > k[i]) : (k[j] < k[i])) begin
               tv = v[i]; v[i] = v[j]; v[j] = tv;
               tk = k[i]; k[i] = k[j]; k[j] = tk;
            end
      return {v[0], v[1], v[2], v[3]};
   endfunction

   function automatic logic [31:0] n8(input logic [127:0] r);
      return {r[103:96], r[71:64], r[39:32], r[7:0]};
   endfunction

   function automatic logic [31:0] rnd_el(input int w);
      logic [31:0] m;
      m = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      case ($urandom_range(7))
         0:       return 32'h0;
         1:       return m;
         2:       return 32'h1 << (w - 1);
         3:       return m >> 1;
         default: return $urandom & m;
      endcase
   endfunction

   task automatic put(input bit v, input bit d, input bit s, input logic [31:0] vec, input logic [31:0] e);
      in_val = v; in_desc = d; in_sgn = s;
      {in0, in1, in2, in3} = vec;
      nxt_exp = e;
   endtask

   task automatic trace();
      $display("trace %0t in %0b/%0b | S1 %0b | S2 %0b | S3 %0b | out %0b/%0b",
               $time, in_val, in_rdy, dut.r_vld[1], dut.r_vld[2], dut.r_vld[3], out_val, out_rdy);
   endtask

   // One cycle, entered at a negedge: score both handshakes that the next posedge completes.
   task automatic tick(input string tag);
      #1;
      if (out_val && out_rdy) begin
         n_out++;
         if (exp_q.size() == 0) chk({tag, "_spur"}, 1, 0);
         else chk(tag, {out0, out1, out2, out3}, exp_q.pop_front());
      end
      acc = in_val && in_rdy;
      if (acc) exp_q.push_back(nxt_exp);
      @(negedge clk);
   endtask

   task automatic drain(input string tag);
      out_rdy = 1'b1;
      in_val  = 1'b0;
      for (int i = 0; i < 12 && exp_q.size() != 0; i++) tick(tag);
      chk({tag, "_left"}, exp_q.size(), 0);
   endtask

   initial begin
      sw_reset = 1'b1;
      repeat (2) @(negedge clk);
      sw_reset = 1'b0;
   end

   for (genvar g = 0; g < 3; g++) begin : g_sw
      localparam int W = (g == 0) ? 2 : ((g == 1) ? 16 : 32);
      logic         v, r, d, s, ir, ov;
      logic [W-1:0] a0, a1, a2, a3, b0, b1, b2, b3;
      logic [127:0] q[$];
      logic [127:0] nx;
      int           nacc;
      bit           done = 1'b0;

      ex_sorter_sorter_valrdy #(.p_nbits(W)) u_dut (
         .clk(clk), .reset(sw_reset), .in_val(v), .in_rdy(ir), .in_desc(d), .in_sgn(s),
         .in0(a0), .in1(a1), .in2(a2), .in3(a3),
         .out_val(ov), .out_rdy(r), .out0(b0), .out1(b1), .out2(b2), .out3(b3)
      );

      initial begin
         bit hold;
         v = 0; r = 1; d = 0; s = 0; a0 = '0; a1 = '0; a2 = '0; a3 = '0;
         nx = '0; nacc = 0; hold = 0;
         repeat (3) @(negedge clk);
         for (int c = 0; c < 4000 && nacc < 500; c++) begin
            if (!hold) begin
               v  = ($urandom_range(3) != 0);
               d  = 1'($urandom_range(1));
               s  = 1'($urandom_range(1));
               a0 = W'(rnd_el(W)); a1 = W'(rnd_el(W));
               a2 = W'(rnd_el(W)); a3 = W'(rnd_el(W));
               nx = ref_sort(W, d, s, 32'(a0), 32'(a1), 32'(a2), 32'(a3));
            end
            r = ($urandom_range(3) != 0);
            #1;
            if (ov && r) begin
               if (q.size() == 0) chk($sformatf("sw%0d_spur", W), 1, 0);
               else chk($sformatf("sw%0d_data", W), {32'(b0), 32'(b1), 32'(b2), 32'(b3)}, q.pop_front());
            end
            hold = v && !ir;
            if (v && ir) begin
               q.push_back(nx);
               nacc++;
            end
            @(negedge clk);
         end
         v = 0; r = 1;
         for (int c = 0; c < 10; c++) begin
            #1;
            if (ov) begin
               if (q.size() == 0) chk($sformatf("sw%0d_spur", W), 1, 0);
               else chk($sformatf("sw%0d_data", W), {32'(b0), 32'(b1), 32'(b2), 32'(b3)}, q.pop_front());
            end
            @(negedge clk);
         end
         chk($sformatf("sw%0d_left", W), q.size(), 0);
         chk($sformatf("sw%0d_count", W), nacc, 500);
         done = 1'b1;
      end
   end

   initial begin
      logic [31:0]  tv[6], te[6], vec;
      bit           td[6], ts[6], hold, d, s;
      int           idx, nacc;
      logic [127:0] r;

      reset = 1'b1; out_rdy = 1'b1;
      put(0, ORDER_ASC, CMP_UNSIGNED, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      #1;
      chk("rst_in_rdy", in_rdy, 0);
      chk("rst_out_val", out_val, 0);
      reset = 1'b0;
      #1;
      chk("rel_in_rdy", in_rdy, 1);
      @(negedge clk);

      // latency and basic ascending sort
      put(1, ORDER_ASC, CMP_UNSIGNED, 32'h03010402, 32'h01020304);
      tick("t1");
      chk("t1_acc", acc, 1);
      put(0, 0, 0, 32'h0, 32'h0);
      for (int k = 1; k <= 3; k++) begin
         trace();
         chk($sformatf("t1_lat%0d", k), out_val, (k == 3));
         tick("t1_data");
      end
      drain("t1");

      // descending and ties
      put(1, ORDER_DESC, CMP_UNSIGNED, 32'h03010402, 32'h04030201); tick("t2_desc");
      put(1, ORDER_ASC,  CMP_UNSIGNED, 32'h05050505, 32'h05050505); tick("t2_eq");
      put(1, ORDER_ASC,  CMP_UNSIGNED, 32'h02070207, 32'h02020707); tick("t2_tie");
      drain("t2");

      // signed then unsigned, back to back
      put(1, ORDER_ASC, CMP_SIGNED,   32'h8001FF00, 32'h80FF0001); tick("t3_sgn");
      chk("t3_acc_a", acc, 1);
      put(1, ORDER_ASC, CMP_UNSIGNED, 32'h8001FF00, 32'h000180FF); tick("t3_uns");
      chk("t3_acc_b", acc, 1);
      put(0, 0, 0, 32'h0, 32'h0);
      tick("t3_gap");
      chk("t3_first", out_val, 1);
      tick("t3_a");
      chk("t3_second", out_val, 1);
      tick("t3_b");
      drain("t3");

      // backpressure: consumer stalls in cycles 2..8
      tv[0] = 32'h10302040; te[0] = 32'h10203040; td[0] = 0; ts[0] = 0;
      tv[1] = 32'h55113322; te[1] = 32'h11223355; td[1] = 0; ts[1] = 0;
      tv[2] = 32'h01020304; te[2] = 32'h04030201; td[2] = 1; ts[2] = 0;
      tv[3] = 32'h9A7F8000; te[3] = 32'h809A007F; td[3] = 0; ts[3] = 1;
      tv[4] = 32'hFFFEFDFC; te[4] = 32'hFCFDFEFF; td[4] = 0; ts[4] = 0;
      tv[5] = 32'hC040C040; te[5] = 32'h4040C0C0; td[5] = 1; ts[5] = 1;
      idx = 0; n_out = 0;
      for (int c = 1; c <= 40 && (idx < 6 || exp_q.size() != 0); c++) begin
         out_rdy = !(c >= 2 && c <= 8);
         if (idx < 6) put(1, td[idx], ts[idx], tv[idx], te[idx]);
         else put(0, 0, 0, 32'h0, 32'h0);
         #1;
         if (c == 3) chk("bp_rdy_c3", in_rdy, 1);
         if (c >= 4 && c <= 8) begin
            chk($sformatf("bp_rdy_c%0d", c), in_rdy, 0);
            chk($sformatf("bp_oval_c%0d", c), out_val, 1);
            chk($sformatf("bp_hold_c%0d", c), {out0, out1, out2, out3}, 32'h10203040);
         end
         tick("bp");
         if (acc) idx++;
      end
      drain("bp");
      chk("bp_count", n_out, 6);

      // random consumer stalls against the reference model
      hold = 0; nacc = 0; r = '0; vec = '0;
      for (int c = 0; c < 3000 && nacc < 200; c++) begin
         if (!hold) begin
            d   = 1'($urandom_range(1));
            s   = 1'($urandom_range(1));
            vec = $urandom;
            r   = ref_sort(8, d, s, 32'(vec[31:24]), 32'(vec[23:16]), 32'(vec[15:8]), 32'(vec[7:0]));
            put(1, d, s, vec, n8(r));
         end
         out_rdy = 1'($urandom_range(1));
         tick("rnd");
         hold = !acc;
         if (acc) nacc++;
      end
      drain("rnd");
      chk("rnd_count", nacc, 200);

      // reset discards in-flight work and refuses input
      put(1, ORDER_ASC,  CMP_UNSIGNED, 32'h44332211, 32'h11223344); tick("t5");
      put(1, ORDER_DESC, CMP_UNSIGNED, 32'h01020304, 32'h04030201); tick("t5");
      reset = 1'b1;
      put(1, ORDER_ASC, CMP_UNSIGNED, 32'hAABBCCDD, 32'h0);
      #1;
      chk("t5_rst_rdy", in_rdy, 0);
      chk("t5_rst_oval", out_val, 0);
      tick("t5_rst");
      exp_q.delete();
      reset = 1'b0;
      put(0, 0, 0, 32'h0, 32'h0);
      chk("t5_post_oval", out_val, 0);
      n_out = 0;
      repeat (5) tick("t5_ghost");
      chk("t5_ghost_cnt", n_out, 0);
      put(1, ORDER_ASC, CMP_UNSIGNED, 32'h09080706, 32'h06070809);
      tick("t5_new");
      chk("t5_acc", acc, 1);
      put(0, 0, 0, 32'h0, 32'h0);
      for (int k = 1; k <= 3; k++) begin
         chk($sformatf("t5_lat%0d", k), out_val, (k == 3));
         tick("t5_data");
      end
      drain("t5");

      for (int i = 0; i < 6000 && !(g_sw[0].done && g_sw[1].done && g_sw[2].done); i++)
         @(negedge clk);
      chk("sweep_done", {g_sw[0].done, g_sw[1].done, g_sw[2].done}, 3'b111);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
